// File: rtl/hazard_scheduler_pkg.sv
// hazard_scheduler_pkg: field widths, forward-select encodings and compare helpers for the hazard unit
package hazard_scheduler_pkg;
  localparam int TNEW_W = 4;
  localparam int REG_W = 5;
  typedef enum logic [1:0] {FWD_D_RF, FWD_D_E, FWD_D_M, FWD_D_W} fwd_d_e;
  typedef enum logic [1:0] {FWD_E_PIPE, FWD_E_M, FWD_E_W} fwd_e_e;
  typedef enum logic {FWD_M_PIPE, FWD_M_W} fwd_m_e;
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction
  function automatic logic ready(input logic [REG_W-1:0] a, p, input logic [TNEW_W-1:0] t);
    return a != '0 && a == p && t == '0;
  endfunction
  function automatic logic pending(input logic [REG_W-1:0] a, p, input logic [TNEW_W-1:0] t, tuse);
    return a != '0 && a == p && t > tuse;
  endfunction
endpackage

// File: rtl/hazard_if.sv
// hazard_if: D-stage demands in, stall and forward selects out
interface hazard_if;
  import hazard_scheduler_pkg::*;
  logic hold;
  logic [TNEW_W-1:0] d_tuse1, d_tuse2, d_tnew;
  logic [REG_W-1:0] d_addr1, d_addr2, d_addrnew;
  logic stall;
  logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;
  logic fwd_m2;
  modport master(output hold, d_tuse1, d_tuse2, d_tnew, d_addr1, d_addr2, d_addrnew,
                 input stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2);
  modport slave(input hold, d_tuse1, d_tuse2, d_tnew, d_addr1, d_addr2, d_addrnew,
                output stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, fwd_m2);
endinterface

// File: rtl/hazard_stage_reg.sv
// hazard_stage_reg: per-stage producer address and remaining Tnew, decremented as it advances
module hazard_stage_reg
  import hazard_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              bubble,
  input  logic [REG_W-1:0]  addr_in,
  input  logic [TNEW_W-1:0] tnew_in,
  output logic [REG_W-1:0]  addr,
  output logic [TNEW_W-1:0] tnew
);
  always_ff @(posedge clk)
    if (!reset) begin
      addr <= '0;
      tnew <= '0;
    end else if (en) begin
      addr <= bubble ? '0 : addr_in;
      tnew <= bubble ? '0 : sat_dec(tnew_in);
    end
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: stall and forwarding control for the 5-stage F/D/E/M/W pipeline
module hazard_scheduler
  import hazard_scheduler_pkg::*;
(
  input logic     clk,
  input logic     reset,
  hazard_if.slave hz
);
  logic [REG_W-1:0] addr_e, addr_m, addr_w, rs_e, rt_e, rt_m;
  logic [TNEW_W-1:0] tnew_e, tnew_m, tnew_w;
  logic en;
  assign en = !hz.hold;
  hazard_stage_reg u_e (.clk(clk), .reset(reset), .en(en), .bubble(hz.stall),
                        .addr_in(hz.d_addrnew), .tnew_in(hz.d_tnew), .addr(addr_e), .tnew(tnew_e));
  hazard_stage_reg u_m (.clk(clk), .reset(reset), .en(en), .bubble(1'b0),
                        .addr_in(addr_e), .tnew_in(tnew_e), .addr(addr_m), .tnew(tnew_m));
  hazard_stage_reg u_w (.clk(clk), .reset(reset), .en(en), .bubble(1'b0),
                        .addr_in(addr_m), .tnew_in(tnew_m), .addr(addr_w), .tnew(tnew_w));
  always_ff @(posedge clk)
    if (!reset) begin
      rs_e <= '0;
      rt_e <= '0;
      rt_m <= '0;
    end else if (en) begin
      rs_e <= hz.stall ? '0 : hz.d_addr1;
      rt_e <= hz.stall ? '0 : hz.d_addr2;
      rt_m <= rt_e;
    end
  // W is never checked for stalls: its Tnew has always drained to zero
  assign hz.stall = pending(hz.d_addr1, addr_e, tnew_e, hz.d_tuse1) | pending(hz.d_addr1, addr_m, tnew_m, hz.d_tuse1)
                  | pending(hz.d_addr2, addr_e, tnew_e, hz.d_tuse2) | pending(hz.d_addr2, addr_m, tnew_m, hz.d_tuse2);
  assign hz.fwd_d1 = ready(hz.d_addr1, addr_e, tnew_e) ? FWD_D_E : ready(hz.d_addr1, addr_m, tnew_m) ? FWD_D_M
                   : ready(hz.d_addr1, addr_w, tnew_w) ? FWD_D_W : FWD_D_RF;
  assign hz.fwd_d2 = ready(hz.d_addr2, addr_e, tnew_e) ? FWD_D_E : ready(hz.d_addr2, addr_m, tnew_m) ? FWD_D_M
                   : ready(hz.d_addr2, addr_w, tnew_w) ? FWD_D_W : FWD_D_RF;
  assign hz.fwd_e1 = ready(rs_e, addr_m, tnew_m) ? FWD_E_M : ready(rs_e, addr_w, tnew_w) ? FWD_E_W : FWD_E_PIPE;
  assign hz.fwd_e2 = ready(rt_e, addr_m, tnew_m) ? FWD_E_M : ready(rt_e, addr_w, tnew_w) ? FWD_E_W : FWD_E_PIPE;
  assign hz.fwd_m2 = ready(rt_m, addr_w, tnew_w) ? FWD_M_W : FWD_M_PIPE;
endmodule

// File: tb/tb_hazard_scheduler.sv
// tb_hazard_scheduler: scenario tasks with a scoreboard of expected stall/forward outputs
module tb_hazard_scheduler;
  import hazard_scheduler_pkg::*;
  typedef struct {
    string name;
    logic [9:0] outs;
  } exp_t;
  logic clk = 0;
  logic reset = 0;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  hazard_if hz();
  hazard_scheduler dut (.clk(clk), .reset(reset), .hz(hz));
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end
  task automatic step(string n, logic [3:0] t1, logic [3:0] t2, logic [4:0] a1, logic [4:0] a2,
                      logic [3:0] tn, logic [4:0] an, logic st, logic [1:0] d1, logic [1:0] d2,
                      logic [1:0] e1, logic [1:0] e2, logic m2);
    exp_t e;
    logic [9:0] got;
    hz.d_tuse1 = t1; hz.d_tuse2 = t2; hz.d_addr1 = a1; hz.d_addr2 = a2;
    hz.d_tnew = tn; hz.d_addrnew = an;
    sb.push_back('{n, {st, d1, d2, e1, e2, m2}});
    @(negedge clk);
    e = sb.pop_front();
    got = {hz.stall, hz.fwd_d1, hz.fwd_d2, hz.fwd_e1, hz.fwd_e2, hz.fwd_m2};
    tests++;
    if (got !== e.outs) begin
      fails++;
      $display("FAIL %s: stall,d1,d2,e1,e2,m2 got %b,%0d,%0d,%0d,%0d,%b want %b,%0d,%0d,%0d,%0d,%b", e.name,
               got[9], got[8:7], got[6:5], got[4:3], got[2:1], got[0],
               e.outs[9], e.outs[8:7], e.outs[6:5], e.outs[4:3], e.outs[2:1], e.outs[0]);
    end
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset = 0;
    hz.hold = 0;
    {hz.d_tuse1, hz.d_tuse2, hz.d_addr1, hz.d_addr2, hz.d_tnew, hz.d_addrnew} = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask
  task automatic test_reset();
    reset = 1;
    hz.hold = 0;
    hz.d_addr1 = 5'd9; hz.d_addr2 = 5'd9; hz.d_addrnew = 5'd9; hz.d_tnew = 4'd3;
    repeat (3) @(posedge clk);
    do_reset();
    tests++;
    if ({dut.addr_e, dut.tnew_e, dut.addr_m, dut.tnew_m, dut.addr_w, dut.tnew_w, dut.rs_e, dut.rt_e, dut.rt_m} !== 42'd0) begin
      fails++;
      $display("FAIL reset_state: got e=%0d/%0d m=%0d/%0d w=%0d/%0d want all 0",
               dut.addr_e, dut.tnew_e, dut.addr_m, dut.tnew_m, dut.addr_w, dut.tnew_w);
    end
    step("reset_outs", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_basic();
    do_reset();
    step("addu_empty", 1, 1, 1, 2, 2, 3, 0, 0, 0, 0, 0, 0);
    tests++;
    if ({dut.addr_e, dut.tnew_e} !== {5'd3, 4'd1}) begin
      fails++;
      $display("FAIL addu_in_e: got addr_e=%0d tnew_e=%0d want 3 1", dut.addr_e, dut.tnew_e);
    end
  endtask
  task automatic test_load_use();
    do_reset();
    step("lw_issue", 1, 1, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0);
    step("lu_stall", 1, 1, 4, 0, 2, 7, 1, 0, 0, 0, 0, 0);
    step("lu_release", 1, 1, 4, 0, 2, 7, 0, 0, 0, 0, 0, 0);
    step("lu_fwd_e1_w", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
  endtask
  task automatic test_branch();
    do_reset();
    step("ori_issue", 1, 1, 1, 0, 2, 5, 0, 0, 0, 0, 0, 0);
    step("beq_stall", 0, 0, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("beq_fwd_d1_m", 0, 0, 5, 0, 0, 0, 0, 2, 0, 0, 0, 0);
  endtask
  task automatic test_store();
    do_reset();
    step("addu6_issue", 1, 1, 1, 2, 2, 6, 0, 0, 0, 0, 0, 0);
    step("sw_no_stall", 1, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sw_fwd_e2_m", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    do_reset();
    step("lw6_issue", 1, 1, 1, 0, 3, 6, 0, 0, 0, 0, 0, 0);
    step("sw_after_lw", 1, 2, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sw_e_no_fwd", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sw_fwd_m2_w", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask
  task automatic test_priority();
    do_reset();
    step("w8_first", 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
    step("w8_second", 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0, 0);
    step("e_beats_m", 0, 0, 8, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    do_reset();
    step("zero_dest", 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step("zero_src", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_hold();
    do_reset();
    step("hold_lw", 1, 1, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0);
    hz.hold = 1;
    for (int i = 0; i < 3; i++) begin
      step("hold_stall", 1, 1, 4, 0, 2, 7, 1, 0, 0, 0, 0, 0);
      tests++;
      if ({dut.addr_e, dut.tnew_e, dut.addr_m, dut.tnew_m, dut.rs_e} !== {5'd4, 4'd2, 5'd0, 4'd0, 5'd0}) begin
        fails++;
        $display("FAIL hold_frozen: got e=%0d/%0d m=%0d/%0d want e=4/2 m=0/0",
                 dut.addr_e, dut.tnew_e, dut.addr_m, dut.tnew_m);
      end
    end
    reset = 0;
    @(posedge clk); #1;
    tests++;
    if ({dut.addr_e, dut.tnew_e, dut.addr_m, dut.tnew_m, dut.addr_w, dut.tnew_w} !== 27'd0) begin
      fails++;
      $display("FAIL hold_reset: got e=%0d/%0d m=%0d/%0d want all 0", dut.addr_e, dut.tnew_e, dut.addr_m, dut.tnew_m);
    end
    reset = 1;
    hz.hold = 0;
    step("after_hold_reset", 1, 1, 4, 0, 2, 7, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    hz.hold = 0;
    {hz.d_tuse1, hz.d_tuse2, hz.d_addr1, hz.d_addr2, hz.d_tnew, hz.d_addrnew} = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_load_use();
    test_branch();
    test_store();
    test_priority();
    test_hold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
